// File: rtl/freq_meter_pkg.sv
// -----------------------------------------------------------------------------
// freq_meter_pkg
// Shared definitions for the frequency meter:
//   - state_e       : FSM state encoding (IDLE / GATE / LATCH)
//   - result_t      : scaled measurement result with saturation flag
//   - DEF_MAIN_CLOCK: default clk_in frequency in Hz
//   - DEF_GATE_DIV  : default gate divider (gate time = 1/GATE_DIV s)
//   - CNT_MAX       : saturation value of the 32-bit counters and result
//   - scale_result(): edge count -> Hz conversion with saturation
// -----------------------------------------------------------------------------
package freq_meter_pkg;

    localparam longint      DEF_MAIN_CLOCK = 50_000_000;
    localparam longint      DEF_GATE_DIV   = 1;
    localparam logic [31:0] CNT_MAX        = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } state_e;

    typedef struct packed {
        logic        ovf;
        logic [31:0] value;
    } result_t;

    // Scales an edge count by the gate divider at full 64-bit precision and
    // saturates to CNT_MAX when the product does not fit or when the edge
    // counter itself already saturated during the window.
    function automatic result_t scale_result(
        input logic [31:0] count,
        input logic [63:0] div,
        input logic        sticky
    );
        logic [63:0] product;
        result_t     res;
        product = 64'(count) * div;
        if (sticky || (product > 64'(CNT_MAX))) begin
            res.ovf   = 1'b1;
            res.value = CNT_MAX;
        end else begin
            res.ovf   = 1'b0;
            res.value = product[31:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous signal into the clk_in domain through a 2-flop
// synchronizer and flags its rising edges with a one-cycle pulse. A third
// flop holds the previous synchronized value. A rising edge on async_in is
// reported as rise_pulse on the third clk_in edge after it is first sampled.
//
// Ports:
//   clk_in     in   clock
//   rst        in   synchronous, active-low reset
//   async_in   in   asynchronous input
//   rise_pulse out  one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module sync_edge_detect (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // NOTE: reset is sampled only on a clock edge (synchronous); rst is not
    // in the sensitivity list, so asserting it between edges does nothing.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each flop take the value its
            // predecessor held before the edge, forming a real shift chain.
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
// Counts rising edges of sig_in during a gate window of MAIN_CLOCK/GATE_DIV
// clk_in cycles and reports the frequency in Hz (edge count * GATE_DIV).
// Windows run once per start pulse, or back-to-back while continuous is high,
// with one dead cycle (LATCH) between consecutive windows.
//
// Parameters:
//   MAIN_CLOCK  clk_in frequency in Hz
//   GATE_DIV    gate time = 1/GATE_DIV s; must divide MAIN_CLOCK and leave
//               a gate of at least 2 cycles
//
// Ports:
//   clk_in      in   system clock
//   rst         in   synchronous, active-low reset
//   sig_in      in   signal under measurement (asynchronous)
//   start       in   single-shot request; ignored while busy
//   continuous  in   repeat windows back-to-back while high
//   freq_out    out  last result in Hz, held until the next result
//   valid       out  one-cycle pulse, high while a new result is presented
//   busy        out  high in GATE and LATCH
//   overflow    out  result saturated; updates together with freq_out
//
// Timing: the result of a window is registered on the edge that leaves the
// last gate cycle, so freq_out/overflow change in the same cycle valid is
// high (the LATCH cycle).
// -----------------------------------------------------------------------------
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter longint MAIN_CLOCK = DEF_MAIN_CLOCK,
    parameter longint GATE_DIV   = DEF_GATE_DIV
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        sig_in,
    input  logic        start,
    input  logic        continuous,
    output logic [31:0] freq_out,
    output logic        valid,
    output logic        busy,
    output logic        overflow
);

    localparam longint      GATE_CYCLES = MAIN_CLOCK / GATE_DIV;
    localparam logic [31:0] GATE_LAST   = 32'(GATE_CYCLES - 1);
    localparam logic [63:0] GATE_DIV_W  = 64'(GATE_DIV);

    // Reject parameter sets that cannot produce an exact, countable window.
    if ((GATE_DIV < 1) || (GATE_DIV > 64'sh0_FFFF_FFFF) ||
        ((MAIN_CLOCK % GATE_DIV) != 0) ||
        (GATE_CYCLES < 2) || (GATE_CYCLES > 64'sh1_0000_0000)) begin : g_bad_params
        $error("freq_meter: GATE_DIV must divide MAIN_CLOCK with 2..2^32 gate cycles");
    end

    // ------------------------------------------------------------------
    // Input synchronization and edge detection
    // ------------------------------------------------------------------
    logic rise_pulse;

    sync_edge_detect u_sync_edge_detect (
        .clk_in     (clk_in),
        .rst        (rst),
        .async_in   (sig_in),
        .rise_pulse (rise_pulse)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e      state_q,    state_d;
    logic [31:0] gate_cnt_q, gate_cnt_d;
    logic [31:0] edge_cnt_q, edge_cnt_d;
    logic        sticky_q,   sticky_d;
    logic [31:0] freq_q,     freq_d;
    logic        ovf_q,      ovf_d;
    logic        valid_q,    valid_d;

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sticky_q   <= 1'b0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sticky_q   <= sticky_d;
            freq_q     <= freq_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Saturating edge counter increment. The incremented value is also
    // the one scaled on the last gate cycle, so an edge landing in that
    // cycle is part of the result.
    // ------------------------------------------------------------------
    logic [31:0] edge_inc;
    logic        sticky_inc;
    result_t     window_res;

    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned; that is what keeps latches out.
        edge_inc   = edge_cnt_q;
        sticky_inc = sticky_q;
        if (rise_pulse) begin
            if (edge_cnt_q == CNT_MAX) begin
                sticky_inc = 1'b1;
            end else begin
                edge_inc = edge_cnt_q + 32'd1;
            end
        end
    end

    assign window_res = scale_result(edge_inc, GATE_DIV_W, sticky_inc);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sticky_d   = sticky_q;
        freq_d     = freq_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Counters are held at zero outside GATE, which both
                // discards stray edges and clears them for the next window.
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sticky_d   = 1'b0;
                if (start || continuous) begin
                    state_d = GATE;
                end
            end

            GATE: begin
                edge_cnt_d = edge_inc;
                sticky_d   = sticky_inc;
                if (gate_cnt_q == GATE_LAST) begin
                    state_d = LATCH;
                    freq_d  = window_res.value;
                    ovf_d   = window_res.ovf;
                    valid_d = 1'b1;
                end else begin
                    gate_cnt_d = gate_cnt_q + 32'd1;
                end
            end

            LATCH: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sticky_d   = 1'b0;
                state_d    = continuous ? GATE : IDLE;
            end

            default: begin
                state_d    = IDLE;
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sticky_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign freq_out = freq_q;
    assign overflow = ovf_q;
    assign valid    = valid_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter
// Self-checking bench for freq_meter. The main instance runs with
// MAIN_CLOCK=1000, GATE_DIV=10 (100-cycle gate). A second instance with
// GATE_DIV=1e9 and a 20-cycle gate exercises the saturation boundary.
// Expected results are queued when a window is launched and compared by a
// monitor whenever valid pulses.
// -----------------------------------------------------------------------------
module tb_freq_meter;

    typedef struct {
        logic [31:0] freq;
        logic        ovf;
    } exp_t;

    logic        clk_in;
    logic        rst;
    logic        sig_in;
    logic        start;
    logic        continuous;
    logic [31:0] freq_out;
    logic        valid;
    logic        busy;
    logic        overflow;

    logic        sig2;
    logic        start2;
    logic [31:0] freq2;
    logic        valid2;
    logic        busy2;
    logic        ovf2;

    int errors       = 0;
    int checks       = 0;
    int valid_count  = 0;
    int valid2_count = 0;
    int gen_half     = 0;
    int sig2_high    = 2;
    int sig2_low     = 2;

    exp_t exp_q[$];
    exp_t exp2_q[$];

    freq_meter #(
        .MAIN_CLOCK (1000),
        .GATE_DIV   (10)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .sig_in     (sig_in),
        .start      (start),
        .continuous (continuous),
        .freq_out   (freq_out),
        .valid      (valid),
        .busy       (busy),
        .overflow   (overflow)
    );

    freq_meter #(
        .MAIN_CLOCK (64'sd20_000_000_000),
        .GATE_DIV   (64'sd1_000_000_000)
    ) dut_ovf (
        .clk_in     (clk_in),
        .rst        (rst),
        .sig_in     (sig2),
        .start      (start2),
        .continuous (1'b0),
        .freq_out   (freq2),
        .valid      (valid2),
        .busy       (busy2),
        .overflow   (ovf2)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Square wave for the main instance; gen_half == 0 hands sig_in over to
    // the test tasks.
    initial begin
        sig_in = 1'b0;
        forever begin
            if (gen_half == 0) begin
                @(negedge clk_in);
            end else begin
                repeat (gen_half) @(negedge clk_in);
                if (gen_half != 0) sig_in = ~sig_in;
            end
        end
    end

    // Free-running wave for the saturation instance, programmable duty.
    initial begin
        sig2 = 1'b0;
        forever begin
            repeat (sig2_low) @(negedge clk_in);
            sig2 = 1'b1;
            repeat (sig2_high) @(negedge clk_in);
            sig2 = 1'b0;
        end
    end

    // Scoreboard monitors.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (valid === 1'b1) begin
                valid_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL main_unexpected_valid: got freq=%0d ovf=%b, expected no result", freq_out, overflow);
                end else begin
                    e = exp_q.pop_front();
                    if (freq_out !== e.freq || overflow !== e.ovf) begin
                        errors++;
                        $display("FAIL main_result: got freq=%0d ovf=%b, expected freq=%0d ovf=%b", freq_out, overflow, e.freq, e.ovf);
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (valid2 === 1'b1) begin
                valid2_count++;
                checks++;
                if (exp2_q.size() == 0) begin
                    errors++;
                    $display("FAIL sat_unexpected_valid: got freq=%0h ovf=%b, expected no result", freq2, ovf2);
                end else begin
                    e = exp2_q.pop_front();
                    if (freq2 !== e.freq || ovf2 !== e.ovf) begin
                        errors++;
                        $display("FAIL sat_result: got freq=%0h ovf=%b, expected freq=%0h ovf=%b", freq2, ovf2, e.freq, e.ovf);
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [31:0] f, input logic o);
        exp_t e;
        e.freq = f;
        e.ovf  = o;
        return e;
    endfunction

    task automatic pulse_start(input bit second);
        @(negedge clk_in);
        if (second) start2 = 1'b1;
        else        start  = 1'b1;
        @(posedge clk_in);
        #1;
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (n < max_cycles && !seen) begin
            @(negedge clk_in);
            n++;
            if (valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_valid2(input int max_cycles, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (n < max_cycles && !seen) begin
            @(negedge clk_in);
            n++;
            if (valid2 === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit busy_seen;
        rst        = 1'b0;
        start      = 1'b0;
        start2     = 1'b0;
        continuous = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++; if (freq_out !== 32'd0) begin errors++; $display("FAIL reset_freq: got %0d expected 0", freq_out); end
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (freq2 !== 32'd0 || ovf2 !== 1'b0) begin errors++; $display("FAIL reset_sat_inst: got freq=%0h ovf=%b expected 0/0", freq2, ovf2); end
        rst = 1'b1;
        busy_seen = 1'b0;
        repeat (5) begin
            @(negedge clk_in);
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        checks++; if (busy_seen) begin errors++; $display("FAIL reset_release_idle: got busy=1 expected 0 without start"); end
    endtask

    task automatic test_single();
        int n;
        bit seen;
        gen_half = 5;
        repeat (30) @(negedge clk_in);
        exp_q.push_back(mk(32'd100, 1'b0));
        pulse_start(1'b0);
        wait_valid(200, n, seen);
        checks++; if (!seen)    begin errors++; $display("FAIL single_valid_seen: got timeout expected valid"); end
        checks++; if (n != 101) begin errors++; $display("FAIL single_latency: got %0d cycles expected 101", n); end
        @(negedge clk_in);
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL single_after: got busy=%b valid=%b expected 0/0", busy, valid); end
        checks++; if (freq_out !== 32'd100) begin errors++; $display("FAIL single_hold: got %0d expected 100", freq_out); end
    endtask

    task automatic test_constant_high();
        int n;
        bit seen;
        gen_half = 0;
        @(negedge clk_in);
        sig_in = 1'b1;
        repeat (10) @(negedge clk_in);
        exp_q.push_back(mk(32'd0, 1'b0));
        pulse_start(1'b0);
        wait_valid(200, n, seen);
        checks++; if (!seen) begin errors++; $display("FAIL const_valid_seen: got timeout expected valid"); end
        @(negedge clk_in);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL const_busy_after: got %b expected 0", busy); end
        sig_in = 1'b0;
    endtask

    task automatic test_continuous();
        int  vn[3];
        int  vcnt;
        int  n;
        int  vc0;
        bit  busy_low;
        gen_half = 10;
        repeat (40) @(negedge clk_in);
        repeat (3) exp_q.push_back(mk(32'd50, 1'b0));
        @(negedge clk_in);
        continuous = 1'b1;
        vcnt     = 0;
        n        = 0;
        busy_low = 1'b0;
        while (vcnt < 3 && n < 500) begin
            @(negedge clk_in);
            n++;
            if (busy !== 1'b1) busy_low = 1'b1;
            if (valid === 1'b1) begin
                vn[vcnt] = n;
                vcnt++;
            end
            // Drop the level halfway through the third window.
            if (vcnt == 2 && n == vn[1] + 50) continuous = 1'b0;
        end
        continuous = 1'b0;
        checks++; if (vcnt != 3) begin errors++; $display("FAIL cont_windows: got %0d valids expected 3", vcnt); end
        checks++; if (vcnt == 3 && (vn[1] - vn[0]) != 101) begin errors++; $display("FAIL cont_spacing_1: got %0d expected 101", vn[1] - vn[0]); end
        checks++; if (vcnt == 3 && (vn[2] - vn[1]) != 101) begin errors++; $display("FAIL cont_spacing_2: got %0d expected 101", vn[2] - vn[1]); end
        checks++; if (busy_low) begin errors++; $display("FAIL cont_busy: got busy low between windows expected high"); end
        vc0 = valid_count;
        @(negedge clk_in);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop_idle: got busy=%b expected 0", busy); end
        repeat (150) @(negedge clk_in);
        checks++; if (valid_count != vc0) begin errors++; $display("FAIL cont_stop_extra: got %0d extra valids expected 0", valid_count - vc0); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        bit busy_seen;
        gen_half = 5;
        pulse_start(1'b0);
        repeat (50) @(negedge clk_in);
        rst = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++; if (freq_out !== 32'd0) begin errors++; $display("FAIL abort_freq: got %0d expected 0", freq_out); end
        checks++; if (busy !== 1'b0 || valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL abort_flags: got busy=%b valid=%b ovf=%b expected 0/0/0", busy, valid, overflow); end
        rst = 1'b1;
        busy_seen = 1'b0;
        repeat (5) begin
            @(negedge clk_in);
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        checks++; if (busy_seen) begin errors++; $display("FAIL abort_release_idle: got busy=1 expected 0"); end
        exp_q.push_back(mk(32'd100, 1'b0));
        pulse_start(1'b0);
        wait_valid(200, n, seen);
        checks++; if (!seen) begin errors++; $display("FAIL abort_restart: got timeout expected valid"); end
    endtask

    task automatic test_ignored_start();
        int n;
        bit seen;
        int vc0;
        gen_half = 5;
        repeat (10) @(negedge clk_in);
        vc0 = valid_count;
        exp_q.push_back(mk(32'd100, 1'b0));
        pulse_start(1'b0);
        repeat (29) @(negedge clk_in);
        pulse_start(1'b0);
        wait_valid(200, n, seen);
        checks++; if (!seen) begin errors++; $display("FAIL busy_start_valid: got timeout expected valid"); end
        repeat (150) @(negedge clk_in);
        checks++; if (valid_count - vc0 != 1) begin errors++; $display("FAIL busy_start_ignored: got %0d valids expected 1", valid_count - vc0); end
    endtask

    // A single edge whose pulse lands in the last gate cycle is counted;
    // one cycle later it falls into LATCH and is dropped.
    task automatic test_final_cycle();
        int n;
        bit seen;
        for (int w = 0; w < 2; w++) begin
            gen_half = 0;
            @(negedge clk_in);
            sig_in = 1'b0;
            repeat (10) @(negedge clk_in);
            exp_q.push_back(mk((w == 0) ? 32'd10 : 32'd0, 1'b0));
            pulse_start(1'b0);
            n    = 0;
            seen = 1'b0;
            while (n < 200 && !seen) begin
                @(negedge clk_in);
                n++;
                if (n == 98 + w) sig_in = 1'b1;
                if (valid === 1'b1) seen = 1'b1;
            end
            checks++; if (!seen) begin errors++; $display("FAIL final_cycle_valid_%0d: got timeout expected valid", w); end
        end
        sig_in = 1'b0;
    endtask

    task automatic test_overflow();
        int n;
        bit seen;
        sig2_high = 2;
        sig2_low  = 2;
        repeat (20) @(negedge clk_in);
        exp2_q.push_back(mk(32'hFFFF_FFFF, 1'b1));
        pulse_start(1'b1);
        wait_valid2(100, n, seen);
        checks++; if (!seen)   begin errors++; $display("FAIL sat_valid_seen: got timeout expected valid"); end
        checks++; if (n != 21) begin errors++; $display("FAIL sat_latency: got %0d cycles expected 21", n); end
        sig2_high = 3;
        sig2_low  = 2;
        repeat (20) @(negedge clk_in);
        exp2_q.push_back(mk(32'd4_000_000_000, 1'b0));
        pulse_start(1'b1);
        wait_valid2(100, n, seen);
        checks++; if (!seen) begin errors++; $display("FAIL sat_boundary_seen: got timeout expected valid"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_constant_high();
        test_continuous();
        test_reset_mid();
        test_ignored_start();
        test_final_cycle();
        test_overflow();
        repeat (5) @(negedge clk_in);
        checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL main_pending: got %0d results outstanding expected 0", exp_q.size()); end
        checks++; if (exp2_q.size() != 0) begin errors++; $display("FAIL sat_pending: got %0d results outstanding expected 0", exp2_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter MAIN_CLOCK, default 50_000_000, frequency of clk_in in Hz.
REQ-002 Parameter GATE_DIV, default 1, gate time = 1/GATE_DIV s; result scaled by GATE_DIV to Hz.
REQ-003 clk_in  input  1  system clock (MAIN_CLOCK Hz).
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 sig_in  input  1  signal under measurement, asynchronous to clk_in.
REQ-006 start  input  1  single-shot measurement request, sampled each clk_in edge.
REQ-007 continuous  input  1  level; when high, windows repeat back-to-back.
REQ-008 freq_out  output  32  last measured frequency in Hz, held until next result.
REQ-009 valid  output  1  one-cycle pulse when freq_out/overflow update.
REQ-010 busy  output  1  high while a gate window or latch cycle is in progress.
REQ-011 overflow  output  1  result saturated; updated together with freq_out.

Function
REQ-012 sig_in SHALL pass a 2-flop synchronizer; a third flop SHALL give the previous value; rising edge = sync high and previous low.
REQ-013 Latency sig_in rising edge to edge-detect pulse SHALL be 3 clk_in cycles.
REQ-014 FSM states SHALL be IDLE, GATE, LATCH.
REQ-015 IDLE -> GATE when start=1 or continuous=1; gate counter and edge counter cleared on entry.
REQ-016 GATE SHALL last exactly GATE_CYCLES = MAIN_CLOCK/GATE_DIV clk_in cycles, counted by a 32-bit gate counter 0..GATE_CYCLES-1.
REQ-017 Each edge-detect pulse during GATE, including the final gate cycle, SHALL increment a 32-bit edge counter.
REQ-018 Edge counter SHALL saturate at 32'hFFFF_FFFF and set an internal sticky overflow bit.
REQ-019 GATE -> LATCH after the final gate cycle; LATCH lasts one cycle.
REQ-020 In LATCH: freq_out <= edge_count*GATE_DIV, computed at 64 bits; if product > 32'hFFFF_FFFF or sticky bit set, freq_out <= 32'hFFFF_FFFF and overflow <= 1, else overflow <= 0; valid = 1 for this cycle only.
REQ-021 LATCH -> GATE if continuous=1, else -> IDLE.
REQ-022 Edges detected during LATCH or IDLE SHALL be discarded (one-cycle dead time between continuous windows).
REQ-023 start asserted while busy=1 SHALL be ignored, not queued.
REQ-024 Dropping continuous during GATE SHALL complete the current window, then return to IDLE.
REQ-025 busy SHALL be 1 in GATE and LATCH, 0 in IDLE.
REQ-026 Correct count guaranteed only when sig_in high and low phases each last >= 2 clk_in periods.

Reset
REQ-027 When rst=0 at a clk_in edge: state IDLE, all counters 0, synchronizer flops 0, freq_out 0, valid 0, busy 0, overflow 0.
REQ-028 Reset mid-window SHALL abort the measurement with no valid pulse; freq_out returns to 0.
REQ-029 First rst=1 cycle SHALL NOT start a window unless start or continuous is high.

Structure
REQ-030 Shared package freq_meter_pkg SHALL hold state encodings (IDLE=2'd0, GATE=2'd1, LATCH=2'd2) and default MAIN_CLOCK/GATE_DIV constants.
REQ-031 Synchronizer and edge detector SHALL be sub-module sync_edge_detect (ports clk_in, rst, async_in, rise_pulse), reusable by other blocks.
REQ-032 A GATE_DIV value not dividing MAIN_CLOCK is disallowed; GATE_CYCLES SHALL be >= 2.

Verification (MAIN_CLOCK=1000, GATE_DIV=10, GATE_CYCLES=100 unless noted)
REQ-033 Reset, then start pulse, sig_in square wave period 10 cycles -> valid after 101 cycles, freq_out=100, overflow=0.
REQ-034 continuous=1, period 20 cycles, 3 windows -> three valid pulses 101 cycles apart, each freq_out=50, busy never low between them.
REQ-035 sig_in constant 1 after reset, start -> freq_out=0, overflow=0, valid once, busy then 0.
REQ-036 rst=0 asserted at gate cycle 50 -> no valid, freq_out=0, state IDLE; second start after release -> normal result.
REQ-037 Second start pulse at gate cycle 30 -> ignored, exactly one valid pulse.
REQ-038 GATE_DIV=1000000000 override with forced edge_count=5 -> freq_out=32'hFFFF_FFFF, overflow=1 on valid.
